uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the memory-subsystem UART receiver.
- Accepts bytes from the host through a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte onto o_tx, one bit per baud period, in the same baud framing the receiver uses.
- All logic is clocked by i_clk. The baud clock i_clk_uart is used only as a rising-edge-detected enable.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO.
// Baud timing comes from the rising edge of i_clk_uart.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_uart,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_tx_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [FIFO_AW:0] LP_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

    state_t             r_state;
    logic [7:0]         r_sh;
    logic [2:0]         r_bit_cnt;
    logic               r_tx;
    logic               r_done;
    logic               r_uart_dly;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    logic w_tick;
    logic w_push;
    logic w_pop;
    logic w_nempty;
    logic w_pop_state;

    assign w_tick      = i_clk_uart & ~r_uart_dly;
    assign o_ready     = (r_count != LP_FULL);
    assign w_push      = i_valid & o_ready;
    assign w_nempty    = (r_count != '0);
    assign w_pop_state = (r_state == S_IDLE) || (r_state == S_STOP);
    // Pop decision uses the pre-edge count, so a same-cycle push is not seen
    assign w_pop       = w_tick & w_nempty & w_pop_state;

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_count   = r_count;
    assign o_busy    = (r_state != S_IDLE) || w_nempty;

    // Delay the baud clock by one i_clk to detect its rising edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_uart_dly <= 1'b0;
        end else begin
            r_uart_dly <= i_clk_uart;
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Frame sequencer: advances and drives the line only on baud ticks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_nempty) begin
                            r_sh    <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_tx      <= r_sh[0];
                        r_sh      <= {1'b0, r_sh[7:1]};
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_sh[0];
                            r_sh      <= {1'b0, r_sh[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        r_done <= 1'b1;
                        if (w_nempty) begin
                            r_sh    <= r_mem[r_rptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx.
// Baud clock is 16 i_clk cycles; bench knows tick edges from ph.
module tb_uart_tx;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_clk_uart = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic [2:0] o_count;
    logic       o_tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int ph = 0;

    uart_tx #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_uart (i_clk_uart),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_count    (o_count),
        .o_tx_done  (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    // Baud clock rises when ph wraps to 0; next posedge is a tick
    always @(negedge i_clk) begin
        ph = (ph + 1) % 16;
        i_clk_uart = (ph < 8);
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic wait_tick();
        do @(posedge i_clk); while (ph != 0);
        #1;
    endtask

    task automatic sync_ph(input int p);
        do begin
            @(negedge i_clk);
            #1;
        end while (ph != p);
    endtask

    // Call just after a negedge; returns just after the next negedge
    task automatic push(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b,
                         input bit first,
                         input int ecnt);
        if (first) wait_tick();
        chk("start", o_tx, 0);
        chk("cnt", o_count, ecnt);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk($sformatf("d%0d_%02h", i, b), o_tx, b[i]);
        end
        wait_tick();
        chk("stop", o_tx, 1);
        chk("done_lo", o_tx_done, 0);
        wait_tick();
        chk("done", o_tx_done, 1);
        @(posedge i_clk);
        #1;
        chk("done_1cyc", o_tx_done, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge i_clk);
        #1;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_cnt", o_count, 0);
        chk("rst_done", o_tx_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            wait_tick();
            chk("idle_tx", o_tx, 1);
        end
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_ready, 1);
        chk("idle_cnt", o_count, 0);

        sync_ph(5);
        push(8'h55);
        frame(8'h55, 1, 0);
        chk("55_busy", o_busy, 0);

        sync_ph(5);
        push(8'hA3);
        push(8'h0F);
        chk("b2b_cnt", o_count, 2);
        frame(8'hA3, 1, 1);
        frame(8'h0F, 0, 0);
        chk("b2b_busy", o_busy, 0);

        sync_ph(1);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        chk("full_ready", o_ready, 0);
        chk("full_cnt", o_count, 4);
        push(8'h05);
        chk("drop_cnt", o_count, 4);
        chk("drop_busy", o_busy, 1);
        frame(8'h01, 1, 3);
        frame(8'h02, 0, 2);
        frame(8'h03, 0, 1);
        frame(8'h04, 0, 0);
        chk("full_end_busy", o_busy, 0);
        wait_tick();
        chk("no5th_tx", o_tx, 1);

        sync_ph(0);
        push(8'hC6);
        chk("same_cnt", o_count, 1);
        chk("same_tx", o_tx, 1);
        frame(8'hC6, 1, 0);

        sync_ph(3);
        push(8'hFF);
        push(8'hFF);
        push(8'hFF);
        wait_tick();
        chk("rs_start", o_tx, 0);
        chk("rs_cnt", o_count, 2);
        repeat (4) wait_tick();
        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rs_tx", o_tx, 1);
        chk("rs_cnt0", o_count, 0);
        chk("rs_busy", o_busy, 0);
        chk("rs_ready", o_ready, 1);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            chk("rs_idle", o_tx, 1);
        end
        chk("rs_end_cnt", o_count, 0);
        chk("rs_end_busy", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
